serial_tx: RTL

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_tx.sv | 135 +++++++++++++
 1 files changed

// File: rtl/serial_tx.sv
// Parallel-to-serial frame transmitter: one start bit (0), WIDTH data bits LSB first,
// one stop bit (1), each held for CLKS_PER_BIT clock cycles.
module serial_tx #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             tx_out,
  output logic             busy,
  output logic             tx_done
);

  // Widths sized so the counters hold their terminal values at the parameter maximums.
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned BitW = $clog2(WIDTH + 1);

  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;

  logic              accept;
  logic              cnt_last;

  assign in_ready = (state_q == StIdle);
  assign busy     = (state_q != StIdle);
  assign tx_out   = tx_q;
  assign tx_done  = done_q;

  assign accept   = in_valid && in_ready;
  assign cnt_last = (cnt_q == CntLast);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (accept) begin
          state_d = StStart;
          shift_d = in_data;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
        end
      end

      StStart: begin
        if (cnt_last) begin
          // Present bit 0 on the line and pre-shift so shift_q[0] is always the next bit.
          state_d = StData;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StData: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (bit_q == BitLast) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + BitW'(1);
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StStop: begin
        if (cnt_last) begin
          state_d = StIdle;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

endmodule
